// File: rtl/alu_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkt_pkg
//  Description : Shared definitions for the UART packet ALU controller:
//                opcode encoding, parser state encoding, header length and
//                small opcode classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkt_pkg;

    // Every packet starts with opcode, reserved, length LSB, length MSB.
    localparam logic [15:0] HDR_LEN = 16'd4;

    typedef enum logic [7:0] {
        OP_ADD  = 8'hA0,
        OP_SUB  = 8'hA1,
        OP_XOR  = 8'hA2,
        OP_ECHO = 8'hEC
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RSVD    = 3'd1,
        S_LEN_LO  = 3'd2,
        S_LEN_HI  = 3'd3,
        S_ECHO    = 3'd4,
        S_OPERAND = 3'd5,
        S_RESULT  = 3'd6,
        S_DRAIN   = 3'd7
    } state_e;

    function automatic logic is_arith_opcode(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
    endfunction

    function automatic logic is_valid_opcode(input logic [7:0] op);
        return (op == OP_ECHO) || is_arith_opcode(op);
    endfunction

endpackage : alu_pkt_pkg
`default_nettype wire

// File: rtl/alu_pkt_accum.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkt_accum
//  Description : Little-endian byte-to-word assembler and accumulator for the
//                packet ALU. The first complete word of a packet loads the
//                accumulator; each later word is added, subtracted or XORed.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                clear_i          - start of a new operand stream
//                byte_valid_i     - byte_i is an accepted operand byte
//                byte_i           - operand byte
//                op_i             - packet opcode (ADD/SUB/XOR)
//                acc_o            - accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pkt_accum
    import alu_pkt_pkg::*;
#(
    parameter int DATA_WIDTH_P    = 8,
    parameter int OPERAND_WIDTH_P = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       byte_valid_i,
    input  logic [DATA_WIDTH_P-1:0]    byte_i,
    input  logic [7:0]                 op_i,
    output logic [OPERAND_WIDTH_P-1:0] acc_o
);

    localparam int BYTES_PER_WORD = OPERAND_WIDTH_P / DATA_WIDTH_P;
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
    localparam int ASM_W          = OPERAND_WIDTH_P - DATA_WIDTH_P;

    // Holds the bytes received so far; newest byte enters at the top so the
    // first byte ends up in the least significant position of the word.
    logic [ASM_W-1:0]           asm_q, asm_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       first_q, first_d;
    logic [OPERAND_WIDTH_P-1:0] acc_q, acc_d;
    logic [OPERAND_WIDTH_P-1:0] word_w;

    assign word_w = {byte_i, asm_q};
    assign acc_o  = acc_q;

    always_comb begin
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        acc_d   = acc_q;
        if (clear_i) begin
            asm_d   = '0;
            cnt_d   = '0;
            first_d = 1'b1;
            acc_d   = '0;
        end else if (byte_valid_i) begin
            asm_d = word_w[OPERAND_WIDTH_P-1:DATA_WIDTH_P];
            if (cnt_q == LAST_BYTE) begin
                cnt_d   = '0;
                first_d = 1'b0;
                if (first_q) begin
                    acc_d = word_w;
                end else begin
                    case (op_i)
                        OP_ADD:  acc_d = acc_q + word_w;
                        OP_SUB:  acc_d = acc_q - word_w;
                        OP_XOR:  acc_d = acc_q ^ word_w;
                        default: acc_d = acc_q;
                    endcase
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            acc_q   <= '0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            acc_q   <= acc_d;
        end
    end

endmodule : alu_pkt_accum
`default_nettype wire

// File: rtl/alu_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkt_ctrl
//  Description : Packet controller between a UART receiver and transmitter.
//                Parses a 4-byte header (opcode, reserved, length LSB/MSB),
//                then echoes the payload, or reduces 32-bit little-endian
//                operands with ADD/SUB/XOR and returns the result LSB first,
//                or drains a rejected packet.
//  Ports       : clk, rst_n                    - clock, async active-low reset
//                rx_tdata/rx_tvalid/rx_tready  - byte stream from UART rx
//                tx_tdata/tx_tvalid/tx_tready  - byte stream to UART tx
//                busy_o                        - packet in progress
//                done_o                        - packet completed (1 cycle)
//                err_o                         - packet rejected (1 cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pkt_ctrl
    import alu_pkt_pkg::*;
#(
    parameter int DATA_WIDTH_P    = 8,   // only 8 is supported
    parameter int OPERAND_WIDTH_P = 32   // multiple of DATA_WIDTH_P
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_P-1:0] rx_tdata,
    input  logic                    rx_tvalid,
    output logic                    rx_tready,
    output logic [DATA_WIDTH_P-1:0] tx_tdata,
    output logic                    tx_tvalid,
    input  logic                    tx_tready,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int BYTES_PER_WORD = OPERAND_WIDTH_P / DATA_WIDTH_P;
    localparam int SEL_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BYTES_PER_WORD - 1);
    localparam logic [15:0] WORD_BYTES    = 16'(BYTES_PER_WORD);

    state_e                    state_q, state_d;
    logic [7:0]                opcode_q, opcode_d;
    logic [7:0]                len_lo_q, len_lo_d;
    logic [15:0]               remaining_q, remaining_d;
    logic [DATA_WIDTH_P-1:0]   tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic [SEL_W-1:0]          byte_sel_q, byte_sel_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                       rx_ready_w;
    logic                       rx_fire_w;
    logic                       tx_fire_w;
    logic [15:0]                length_w;
    logic [15:0]                rem_load_w;
    logic                       acc_clear_w;
    logic                       acc_byte_valid_w;
    logic [OPERAND_WIDTH_P-1:0] acc_w;
    logic [DATA_WIDTH_P-1:0]    res_byte_w;

    alu_pkt_accum #(
        .DATA_WIDTH_P    (DATA_WIDTH_P),
        .OPERAND_WIDTH_P (OPERAND_WIDTH_P)
    ) u_accum (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (acc_clear_w),
        .byte_valid_i (acc_byte_valid_w),
        .byte_i       (rx_tdata),
        .op_i         (opcode_q),
        .acc_o        (acc_w)
    );

    // Receive-side ready per state. In ECHO the single tx holding register
    // must be empty before another byte is taken, and nothing beyond the
    // payload may be swallowed.
    always_comb begin
        rx_ready_w = 1'b0;
        case (state_q)
            S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN:
                rx_ready_w = 1'b1;
            S_ECHO:
                rx_ready_w = !tx_valid_q && (remaining_q != 16'd0);
            default:
                rx_ready_w = 1'b0;
        endcase
    end

    // Gated by rst_n so ready is low for the whole reset and high on the
    // first cycle after release (state is IDLE then).
    assign rx_tready = rst_n & rx_ready_w;

    // Result byte selected from the accumulator, LSB first.
    always_comb begin
        res_byte_w = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_sel_q == SEL_W'(i)) begin
                res_byte_w = acc_w[i*DATA_WIDTH_P +: DATA_WIDTH_P];
            end
        end
    end

    // In RESULT the accumulator and byte select are frozen until handshake,
    // so the muxed output stays stable while stalled.
    assign tx_tvalid = tx_valid_q | (state_q == S_RESULT);
    assign tx_tdata  = (state_q == S_RESULT) ? res_byte_w : tx_data_q;

    assign rx_fire_w  = rx_tvalid & rx_tready;
    assign tx_fire_w  = tx_tvalid & tx_tready;
    assign length_w   = {rx_tdata, len_lo_q};
    assign rem_load_w = length_w - HDR_LEN;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign err_o  = err_q;

    always_comb begin
        state_d          = state_q;
        opcode_d         = opcode_q;
        len_lo_d         = len_lo_q;
        remaining_d      = remaining_q;
        tx_data_d        = tx_data_q;
        tx_valid_d       = tx_valid_q;
        byte_sel_d       = byte_sel_q;
        done_d           = 1'b0;
        err_d            = 1'b0;
        acc_clear_w      = 1'b0;
        acc_byte_valid_w = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_fire_w) begin
                    opcode_d = rx_tdata;
                    state_d  = S_RSVD;
                end
            end

            S_RSVD: begin
                if (rx_fire_w) begin
                    state_d = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (rx_fire_w) begin
                    len_lo_d = rx_tdata;
                    state_d  = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (rx_fire_w) begin
                    if (length_w < HDR_LEN) begin
                        // Length shorter than the header itself.
                        remaining_d = 16'd0;
                        err_d       = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        remaining_d = rem_load_w;
                        if (!is_valid_opcode(opcode_q)) begin
                            err_d   = 1'b1;
                            state_d = (rem_load_w == 16'd0) ? S_IDLE : S_DRAIN;
                        end else if (opcode_q == OP_ECHO) begin
                            if (rem_load_w == 16'd0) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_ECHO;
                            end
                        end else if ((rem_load_w == 16'd0) ||
                                     ((rem_load_w % WORD_BYTES) != 16'd0)) begin
                            // Arithmetic payload must be whole operand words.
                            err_d   = 1'b1;
                            state_d = (rem_load_w == 16'd0) ? S_IDLE : S_DRAIN;
                        end else begin
                            acc_clear_w = 1'b1;
                            state_d     = S_OPERAND;
                        end
                    end
                end
            end

            S_ECHO: begin
                if (rx_fire_w) begin
                    tx_data_d   = rx_tdata;
                    tx_valid_d  = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                end else if (tx_fire_w) begin
                    tx_valid_d = 1'b0;
                    if (remaining_q == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_OPERAND: begin
                if (rx_fire_w) begin
                    acc_byte_valid_w = 1'b1;
                    remaining_d      = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        byte_sel_d = '0;
                        state_d    = S_RESULT;
                    end
                end
            end

            S_RESULT: begin
                if (tx_fire_w) begin
                    if (byte_sel_q == LAST_SEL) begin
                        byte_sel_d = '0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        byte_sel_d = byte_sel_q + SEL_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (rx_fire_w) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            remaining_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            byte_sel_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            remaining_q <= remaining_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            byte_sel_q  <= byte_sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule : alu_pkt_ctrl
`default_nettype wire

// File: tb/tb_alu_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pkt_ctrl
//  Description : Self-checking bench for alu_pkt_ctrl. A packet-level model
//                turns the rx byte stream into the ordered list of events the
//                controller must produce (tx bytes, done, err); a monitor
//                compares every tx handshake and pulse against that list and
//                checks tx stability under back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pkt_ctrl;

    localparam int EV_DONE = 256;
    localparam int EV_ERR  = 257;

    typedef logic [7:0] bq_t[$];
    typedef int         eq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int tx_mode = 0;   // 0: random ready, 1: 10-cycle stall per byte, 2: never ready

    alu_pkt_ctrl #(
        .DATA_WIDTH_P    (8),
        .OPERAND_WIDTH_P (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic void chk_events(input string name, input eq_t got, input eq_t exp);
        int bad;
        bad = (got.size() != exp.size()) ? 1 : 0;
        if (bad == 0) begin
            foreach (exp[k]) if (got[k] != exp[k]) bad = 1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: model gave %0d events, expected %0d events (or contents differ)",
                     name, got.size(), exp.size());
        end
    endfunction

    // Packet-level reference: what the controller must emit for a stream.
    function automatic eq_t model_stream(input bq_t s);
        eq_t        ev;
        int         i;
        int         len;
        int         rem;
        logic [7:0] op;
        logic [31:0] acc;
        logic [31:0] word;
        i = 0;
        while (i + 4 <= s.size()) begin
            op  = s[i];
            len = int'(s[i+2]) + 256 * int'(s[i+3]);
            i  += 4;
            if (len < 4) begin
                ev.push_back(EV_ERR);
            end else begin
                rem = len - 4;
                if (op == 8'hEC) begin
                    for (int k = 0; k < rem; k++) ev.push_back(int'(s[i+k]));
                    ev.push_back(EV_DONE);
                end else if (op == 8'hA0 || op == 8'hA1 || op == 8'hA2) begin
                    if (rem == 0 || (rem % 4) != 0) begin
                        ev.push_back(EV_ERR);
                    end else begin
                        acc = 32'd0;
                        for (int w = 0; w < rem / 4; w++) begin
                            word = {s[i+4*w+3], s[i+4*w+2], s[i+4*w+1], s[i+4*w]};
                            if (w == 0)           acc = word;
                            else if (op == 8'hA0) acc = acc + word;
                            else if (op == 8'hA1) acc = acc - word;
                            else                  acc = acc ^ word;
                        end
                        for (int b = 0; b < 4; b++) ev.push_back(int'((acc >> (8*b)) & 32'hFF));
                        ev.push_back(EV_DONE);
                    end
                end else begin
                    ev.push_back(EV_ERR);
                end
                i += rem;
            end
        end
        return ev;
    endfunction

    function automatic bq_t gen_packet(input int kind);
        bq_t        p;
        int         rem;
        int         len;
        logic [7:0] op;
        rem = 0;
        case (kind)
            0: begin op = 8'hEC; rem = int'($urandom_range(0, 6)); end
            1: begin op = 8'hA0 + 8'($urandom_range(0, 2)); rem = 4 * int'($urandom_range(1, 3)); end
            2: begin
                op  = 8'hA0 + 8'($urandom_range(0, 2));
                rem = int'($urandom_range(0, 6));
                if (rem >= 4) rem++;
            end
            3: begin
                op = 8'($urandom);
                while (op == 8'hEC || op == 8'hA0 || op == 8'hA1 || op == 8'hA2) op = 8'($urandom);
                rem = int'($urandom_range(0, 5));
            end
            default: begin
                op = 8'($urandom);
                p.push_back(op);
                p.push_back(8'($urandom));
                p.push_back(8'($urandom_range(0, 3)));
                p.push_back(8'h00);
                return p;
            end
        endcase
        len = rem + 4;
        p.push_back(op);
        p.push_back(8'($urandom));
        p.push_back(8'(len));
        p.push_back(8'(len >> 8));
        for (int k = 0; k < rem; k++) p.push_back(8'($urandom));
        return p;
    endfunction

    function automatic void take_event(input string name, input int ev);
        int e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: unexpected event %0h, none expected", name, ev);
        end else begin
            e = exp_q.pop_front();
            chk(name, ev, e);
        end
    endfunction

    // Starts and ends half a time-step after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rx_tready) break;
            n++;
            if (n > 3000) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_accept_timeout: byte %0h not accepted after %0d cycles", b, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'($urandom);
        repeat (int'($urandom_range(0, 2))) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_stream(input bq_t s);
        foreach (s[k]) send_byte(s[k]);
    endtask

    task automatic run_stream(input bq_t s);
        eq_t e;
        e = model_stream(s);
        foreach (e[k]) exp_q.push_back(e[k]);
        send_stream(s);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d events outstanding, busy=%0b", name, exp_q.size(), busy_o);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        chk({name, "_busy_after"}, int'(busy_o), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t v;
        eq_t e;
        int  n;

        rst_n     = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        tx_tready = 1'b0;

        // Pin the model against hand-computed results.
        v = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        e = '{'h41, 'h42, 'h43, EV_DONE};
        chk_events("model_echo", model_stream(v), e);
        v = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        e = '{'h01, 'h00, 'h00, 'h00, EV_DONE};
        chk_events("model_add_wrap", model_stream(v), e);
        v = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        e = '{'hFE, 'hFF, 'hFF, 'hFF, EV_DONE};
        chk_events("model_sub", model_stream(v), e);
        v = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        e = '{EV_ERR, 'h5A, EV_DONE};
        chk_events("model_bad_op", model_stream(v), e);
        v = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        e = '{EV_ERR};
        chk_events("model_add_len10", model_stream(v), e);

        fork
            // Monitor: outputs sampled on the falling edge.
            begin
                logic       hold;
                logic [7:0] hold_data;
                hold      = 1'b0;
                hold_data = 8'h00;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        hold = 1'b0;
                    end else begin
                        if (done_o || err_o) chk("done_err_exclusive", int'(done_o & err_o), 0);
                        if (hold) begin
                            chk("tx_hold_valid", int'(tx_tvalid), 1);
                            if (tx_tvalid) chk("tx_hold_data", int'(tx_tdata), int'(hold_data));
                        end
                        hold      = tx_tvalid && !tx_tready;
                        hold_data = tx_tdata;
                        if (tx_tvalid && tx_tready) take_event("tx_byte", int'(tx_tdata));
                        if (done_o) take_event("done_pulse", EV_DONE);
                        if (err_o)  take_event("err_pulse", EV_ERR);
                    end
                end
            end
            // tx_tready driver.
            begin
                int stall;
                stall = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    case (tx_mode)
                        0: tx_tready = ($urandom_range(0, 3) != 0);
                        1: begin
                            if (tx_tvalid) begin
                                if (stall >= 10) begin
                                    tx_tready = 1'b1;
                                    stall     = 0;
                                end else begin
                                    tx_tready = 1'b0;
                                    stall++;
                                end
                            end else begin
                                tx_tready = 1'b0;
                            end
                        end
                        default: tx_tready = 1'b0;
                    endcase
                end
            end
            // Watchdog.
            begin
                #(10 * 60000);
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset_tx_tvalid", int'(tx_tvalid), 0);
        chk("reset_tx_tdata",  int'(tx_tdata),  0);
        chk("reset_rx_tready", int'(rx_tready), 0);
        chk("reset_busy",      int'(busy_o),    0);
        chk("reset_done",      int'(done_o),    0);
        chk("reset_err",       int'(err_o),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_rx_tready", int'(rx_tready), 1);

        // Directed packets.
        v = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        run_stream(v);
        wait_idle("echo");

        v = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        run_stream(v);
        wait_idle("add_wrap");

        tx_mode = 1;
        v = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        run_stream(v);
        wait_idle("sub_stall");
        tx_mode = 0;

        v = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        run_stream(v);
        wait_idle("bad_op_then_echo");

        v = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_stream(v);
        wait_idle("add_len10");

        // Random back-to-back packet streams.
        for (int batch = 0; batch < 3; batch++) begin
            v.delete();
            for (int p = 0; p < 20; p++) begin
                bq_t pk;
                pk = gen_packet(int'($urandom_range(0, 4)));
                foreach (pk[k]) v.push_back(pk[k]);
            end
            run_stream(v);
            wait_idle("random_batch");
        end

        // Reset while an XOR result is waiting on the transmitter.
        tx_mode = 2;
        v = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'hFF, 8'h00, 8'h55, 8'hAA};
        send_stream(v);
        n = 0;
        while (!tx_tvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("xor_result_pending", int'(tx_tvalid), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_tx_tvalid", int'(tx_tvalid), 0);
        chk("mid_reset_tx_tdata",  int'(tx_tdata),  0);
        chk("mid_reset_busy",      int'(busy_o),    0);
        chk("mid_reset_rx_tready", int'(rx_tready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("after_reset_rx_tready", int'(rx_tready), 1);
        tx_mode = 0;
        repeat (4) begin
            @(negedge clk);
            chk("after_reset_no_tx", int'(tx_tvalid), 0);
        end
        @(posedge clk);
        #1;
        v = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hA5, 8'h3C};
        run_stream(v);
        wait_idle("echo_after_reset");

        chk("final_events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_pkt_ctrl
`default_nettype wire
